core_mem_arbiter: RTL and testbench

//  Responder for the core's instruction-fetch bus and data bus. Arbitrates the two

---
 rtl/core_mem_arbiter_if.sv | 42 ++++
 rtl/core_mem_arbiter.sv | 118 +++++++++++
 tb/tb_core_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_arbiter_if.sv
// Bundle of the fetch bus, data bus and downstream memory port around the arbiter.
// The slave modport is the arbiter's view; master is the core and memory side.
interface core_mem_arbiter_if;
  logic [18:0] instr_m_addr;
  logic [15:0] instr_m_data_out;
  logic        instr_m_access;
  logic        instr_m_ack;

  logic [18:0] data_m_addr;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out;
  logic        data_m_access;
  logic        data_m_ack;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;

  logic [18:0] q_m_addr;
  logic [15:0] q_m_data_in;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_ack;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;

  modport slave (
    input  instr_m_addr, instr_m_access,
    output instr_m_data_out, instr_m_ack,
    input  data_m_addr, data_m_data_in, data_m_access, data_m_wr_en, data_m_bytesel,
    output data_m_data_out, data_m_ack,
    output q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel,
    input  q_m_data_in, q_m_ack
  );

  modport master (
    output instr_m_addr, instr_m_access,
    input  instr_m_data_out, instr_m_ack,
    output data_m_addr, data_m_data_in, data_m_access, data_m_wr_en, data_m_bytesel,
    input  data_m_data_out, data_m_ack,
    input  q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel,
    output q_m_data_in, q_m_ack
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port, one transaction in flight.
// Request->q_m_access 1 cycle, q_m_ack->requester ack 1 cycle; memory stalls by delaying q_m_ack.
module core_mem_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input logic             clk,
  input logic             reset,
  core_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic G_INSTR = 1'b0;
  localparam logic G_DATA  = 1'b1;

  state_t      r_state;
  logic        r_grant;
  logic        r_last_grant;
  logic [18:0] r_q_addr;
  logic [15:0] r_q_data_out;
  logic        r_q_access;
  logic        r_q_wr_en;
  logic [1:0]  r_q_bytesel;
  logic        r_instr_ack;
  logic        r_data_ack;
  logic [15:0] r_instr_data_out;
  logic [15:0] r_data_data_out;

  logic        w_any_req;
  logic        w_pick;

  assign w_any_req = bus.instr_m_access | bus.data_m_access;

  // Under contention, round-robin favours whoever did not win last time.
  always_comb begin
    w_pick = G_INSTR;
    if (bus.instr_m_access && bus.data_m_access) begin
      w_pick = (ROUND_ROBIN != 0) ? ~r_last_grant : G_DATA;
    end else if (bus.data_m_access) begin
      w_pick = G_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_grant          <= G_INSTR;
      r_last_grant     <= G_INSTR;
      r_q_addr         <= '0;
      r_q_data_out     <= '0;
      r_q_access       <= 1'b0;
      r_q_wr_en        <= 1'b0;
      r_q_bytesel      <= '0;
      r_instr_ack      <= 1'b0;
      r_data_ack       <= 1'b0;
      r_instr_data_out <= '0;
      r_data_data_out  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant    <= w_pick;
            r_q_access <= 1'b1;
            r_state    <= S_SERVE;
            if (w_pick == G_DATA) begin
              r_q_addr     <= bus.data_m_addr;
              r_q_data_out <= bus.data_m_data_in;
              r_q_wr_en    <= bus.data_m_wr_en;
              r_q_bytesel  <= bus.data_m_bytesel;
            end else begin
              r_q_addr     <= bus.instr_m_addr;
              r_q_data_out <= '0;
              r_q_wr_en    <= 1'b0;
              r_q_bytesel  <= 2'b11;
            end
          end
        end
        S_SERVE: begin
          // Read data is returned on writes too; requesters simply ignore it.
          if (bus.q_m_ack) begin
            r_q_access       <= 1'b0;
            r_instr_ack      <= (r_grant == G_INSTR);
            r_data_ack       <= (r_grant == G_DATA);
            r_instr_data_out <= bus.q_m_data_in;
            r_data_data_out  <= bus.q_m_data_in;
            r_state          <= S_RESP;
          end
        end
        S_RESP: begin
          r_instr_ack      <= 1'b0;
          r_data_ack       <= 1'b0;
          r_instr_data_out <= '0;
          r_data_data_out  <= '0;
          r_last_grant     <= r_grant;
          r_state          <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.q_m_addr         = r_q_addr;
  assign bus.q_m_data_out     = r_q_data_out;
  assign bus.q_m_access       = r_q_access;
  assign bus.q_m_wr_en        = r_q_wr_en;
  assign bus.q_m_bytesel      = r_q_bytesel;
  assign bus.instr_m_ack      = r_instr_ack;
  assign bus.data_m_ack       = r_data_ack;
  assign bus.instr_m_data_out = r_instr_data_out;
  assign bus.data_m_data_out  = r_data_data_out;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: round-robin instance driven by hand, fixed-priority
// instance behind a zero-wait memory, plus a short randomised scoreboard run.
module tb_core_mem_arbiter;

  logic clk;
  logic reset;

  core_mem_arbiter_if bus ();
  core_mem_arbiter_if fbus ();

  core_mem_arbiter #(.ROUND_ROBIN(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  core_mem_arbiter #(.ROUND_ROBIN(0)) dut_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (fbus)
  );

  // Zero-wait memory for the fixed-priority instance, read data = low address bits.
  assign fbus.q_m_ack     = fbus.q_m_access;
  assign fbus.q_m_data_in = fbus.q_m_addr[15:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.instr_m_addr    = '0;
    bus.instr_m_access  = 1'b0;
    bus.data_m_addr     = '0;
    bus.data_m_data_in  = '0;
    bus.data_m_access   = 1'b0;
    bus.data_m_wr_en    = 1'b0;
    bus.data_m_bytesel  = '0;
    bus.q_m_data_in     = '0;
    bus.q_m_ack         = 1'b0;
    fbus.instr_m_addr   = '0;
    fbus.instr_m_access = 1'b0;
    fbus.data_m_addr    = '0;
    fbus.data_m_data_in = '0;
    fbus.data_m_access  = 1'b0;
    fbus.data_m_wr_en   = 1'b0;
    fbus.data_m_bytesel = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [18:0] i_addr, d_addr;
  logic [15:0] exp_data;
  logic        exp_vld, exp_bus;
  logic [1:0]  obs_ack;
  int          n_req, n_ack, n_i_ack, n_d_ack;

  initial begin
    reset = 1'b0;
    clear_inputs();

    // Reset state
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_q_access", 32'(bus.q_m_access), 32'd0);
    chk("rst_q_addr",   32'(bus.q_m_addr),   32'd0);
    chk("rst_acks",     32'({bus.instr_m_ack, bus.data_m_ack}), 32'd0);
    chk("rst_douts",    32'({bus.instr_m_data_out, bus.data_m_data_out}), 32'd0);
    reset = 1'b0;

    // Single fetch read, two wait states
    bus.instr_m_addr   = 19'h00100;
    bus.instr_m_access = 1'b1;
    tick();
    chk("rd_q_access", 32'(bus.q_m_access),  32'd1);
    chk("rd_q_addr",   32'(bus.q_m_addr),    32'h00100);
    chk("rd_q_wr_en",  32'(bus.q_m_wr_en),   32'd0);
    chk("rd_q_bysel",  32'(bus.q_m_bytesel), 32'd3);
    chk("rd_q_dout",   32'(bus.q_m_data_out), 32'd0);
    tick();
    tick();
    chk("rd_wait_access", 32'(bus.q_m_access), 32'd1);
    chk("rd_wait_acks",   32'({bus.instr_m_ack, bus.data_m_ack}), 32'd0);
    bus.q_m_ack     = 1'b1;
    bus.q_m_data_in = 16'hBEEF;
    tick();
    bus.q_m_ack        = 1'b0;
    bus.instr_m_access = 1'b0;
    chk("rd_i_ack",     32'(bus.instr_m_ack),      32'd1);
    chk("rd_i_dout",    32'(bus.instr_m_data_out), 32'hBEEF);
    chk("rd_d_ack",     32'(bus.data_m_ack),       32'd0);
    chk("rd_resp_qacc", 32'(bus.q_m_access),       32'd0);
    tick();
    chk("rd_ack_gone",  32'(bus.instr_m_ack),      32'd0);
    chk("rd_dout_zero", 32'(bus.instr_m_data_out), 32'd0);

    // Byte write, zero-wait memory: ack visible in the third cycle
    do_reset();
    bus.data_m_addr    = 19'h1FFFF;
    bus.data_m_data_in = 16'h12AB;
    bus.data_m_bytesel = 2'b01;
    bus.data_m_wr_en   = 1'b1;
    bus.data_m_access  = 1'b1;
    tick();
    chk("wr_q_addr",  32'(bus.q_m_addr),     32'h1FFFF);
    chk("wr_q_dout",  32'(bus.q_m_data_out), 32'h12AB);
    chk("wr_q_wr_en", 32'(bus.q_m_wr_en),    32'd1);
    chk("wr_q_bysel", 32'(bus.q_m_bytesel),  32'd1);
    chk("wr_early",   32'(bus.data_m_ack),   32'd0);
    bus.q_m_ack     = 1'b1;
    bus.q_m_data_in = 16'h5A5A;
    tick();
    bus.q_m_ack       = 1'b0;
    bus.data_m_access = 1'b0;
    chk("wr_d_ack",  32'(bus.data_m_ack),      32'd1);
    chk("wr_d_dout", 32'(bus.data_m_data_out), 32'h5A5A);
    chk("wr_i_ack",  32'(bus.instr_m_ack),     32'd0);
    tick();
    chk("wr_ack_gone", 32'(bus.data_m_ack), 32'd0);

    // Contention with round robin: D, I, D, I
    do_reset();
    bus.instr_m_addr   = 19'h00111;
    bus.data_m_addr    = 19'h00222;
    bus.instr_m_access = 1'b1;
    bus.data_m_access  = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("rr_gnt_addr", 32'(bus.q_m_addr), (t % 2 == 0) ? 32'h00222 : 32'h00111);
      bus.q_m_ack     = 1'b1;
      bus.q_m_data_in = 16'h1000 + 16'(t);
      tick();
      bus.q_m_ack = 1'b0;
      chk("rr_ack", 32'({bus.data_m_ack, bus.instr_m_ack}), (t % 2 == 0) ? 32'd2 : 32'd1);
      chk("rr_dout", 32'((t % 2 == 0) ? bus.data_m_data_out : bus.instr_m_data_out),
          32'h1000 + 32'(t));
      tick();
    end
    bus.instr_m_access = 1'b0;
    bus.data_m_access  = 1'b0;

    // Contention with fixed priority: data wins every time
    do_reset();
    fbus.instr_m_addr   = 19'h00111;
    fbus.data_m_addr    = 19'h00222;
    fbus.instr_m_access = 1'b1;
    fbus.data_m_access  = 1'b1;
    n_i_ack = 0;
    n_d_ack = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (fbus.instr_m_ack) n_i_ack++;
      if (fbus.data_m_ack) begin
        n_d_ack++;
        chk("fp_dout", 32'(fbus.data_m_data_out), 32'h0222);
      end
    end
    chk("fp_d_acks", 32'(n_d_ack), 32'd4);
    chk("fp_i_acks", 32'(n_i_ack), 32'd0);
    fbus.instr_m_access = 1'b0;
    fbus.data_m_access  = 1'b0;

    // Reset during SERVE, then a stale downstream ack
    do_reset();
    bus.instr_m_addr   = 19'h00ABC;
    bus.instr_m_access = 1'b1;
    tick();
    chk("mid_serve", 32'(bus.q_m_access), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.instr_m_access = 1'b0;
    chk("mid_rst_qacc", 32'(bus.q_m_access), 32'd0);
    chk("mid_rst_acks", 32'({bus.instr_m_ack, bus.data_m_ack}), 32'd0);
    tick();
    bus.q_m_ack     = 1'b1;
    bus.q_m_data_in = 16'hDEAD;
    tick();
    bus.q_m_ack = 1'b0;
    chk("stale_acks", 32'({bus.instr_m_ack, bus.data_m_ack}), 32'd0);
    tick();
    chk("stale_acks2", 32'({bus.instr_m_ack, bus.data_m_ack}), 32'd0);
    chk("stale_qacc",  32'(bus.q_m_access), 32'd0);

    // Fetch drops access mid-SERVE: still completes, acked once
    do_reset();
    bus.instr_m_addr   = 19'h00042;
    bus.instr_m_access = 1'b1;
    tick();
    bus.instr_m_access = 1'b0;
    tick();
    chk("drop_qacc", 32'(bus.q_m_access), 32'd1);
    chk("drop_addr", 32'(bus.q_m_addr),   32'h00042);
    bus.q_m_ack     = 1'b1;
    bus.q_m_data_in = 16'h7777;
    tick();
    bus.q_m_ack = 1'b0;
    chk("drop_ack",  32'(bus.instr_m_ack),      32'd1);
    chk("drop_dout", 32'(bus.instr_m_data_out), 32'h7777);
    tick();
    chk("drop_once", 32'(bus.instr_m_ack), 32'd0);
    tick();
    chk("drop_no_new", 32'(bus.q_m_access), 32'd0);

    // Spurious downstream ack in IDLE
    bus.q_m_ack = 1'b1;
    tick();
    tick();
    bus.q_m_ack = 1'b0;
    chk("spur_acks", 32'({bus.instr_m_ack, bus.data_m_ack}), 32'd0);
    chk("spur_qacc", 32'(bus.q_m_access), 32'd0);

    // Randomised run: fetch addresses have bit 18 clear, data addresses set
    do_reset();
    exp_vld = 1'b0;
    exp_bus = 1'b0;
    exp_data = '0;
    i_addr = '0;
    d_addr = '0;
    n_req = 0;
    n_ack = 0;
    for (int c = 0; c < 420; c++) begin
      tick();
      obs_ack = {bus.data_m_ack, bus.instr_m_ack};
      chk("rnd_ack", 32'(obs_ack), exp_vld ? (exp_bus ? 32'd2 : 32'd1) : 32'd0);
      n_ack += int'(obs_ack[0]) + int'(obs_ack[1]);
      if (exp_vld) begin
        chk("rnd_dat", 32'(exp_bus ? bus.data_m_data_out : bus.instr_m_data_out), 32'(exp_data));
        if (exp_bus) bus.data_m_access = 1'b0;
        else         bus.instr_m_access = 1'b0;
        exp_vld = 1'b0;
      end
      if (bus.q_m_access && $urandom_range(0, 2) == 0) begin
        exp_bus  = bus.q_m_addr[18];
        exp_data = 16'($urandom);
        exp_vld  = 1'b1;
        chk("rnd_pend", 32'(exp_bus ? bus.data_m_access : bus.instr_m_access), 32'd1);
        chk("rnd_addr", 32'(bus.q_m_addr), 32'(exp_bus ? d_addr : i_addr));
        bus.q_m_ack     = 1'b1;
        bus.q_m_data_in = exp_data;
      end else begin
        bus.q_m_ack     = !bus.q_m_access && ($urandom_range(0, 7) == 0);
        bus.q_m_data_in = 16'($urandom);
      end
      if (c < 380 && obs_ack == 2'b00) begin
        if (!bus.instr_m_access && $urandom_range(0, 3) == 0) begin
          i_addr             = {1'b0, 18'($urandom)};
          bus.instr_m_addr   = i_addr;
          bus.instr_m_access = 1'b1;
          n_req++;
        end
        if (!bus.data_m_access && $urandom_range(0, 3) == 0) begin
          d_addr             = {1'b1, 18'($urandom)};
          bus.data_m_addr    = d_addr;
          bus.data_m_data_in = 16'($urandom);
          bus.data_m_wr_en   = 1'($urandom);
          bus.data_m_bytesel = 2'($urandom_range(1, 3));
          bus.data_m_access  = 1'b1;
          n_req++;
        end
      end
    end
    bus.q_m_ack = 1'b0;
    chk("rnd_count", 32'(n_ack), 32'(n_req));
    chk("rnd_drained", 32'({bus.instr_m_access, bus.data_m_access}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
